// File: rtl/audio_pkg.sv
// Types shared by the audio front end and the effect chain.
`timescale 1ns/1ps
package audio_pkg;
    localparam int SAMPLE_W = 24;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs.
`timescale 1ns/1ps
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: synchronised sclk/lrck/sdin to signed samples with a valid strobe.
// Define I2S_RX_STEREO_AVG_EN to output the L/R average instead of the left word.
// state | meaning: IDLE wait first ws_edge; DELAY drop trailing bit; SHIFT capture; PAD ignore to ws_edge
`timescale 1ns/1ps
module i2s_rx
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = SAMPLE_W,
    parameter int SLOT_BITS  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         lrck,
    input  logic                         sdin,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         vld_o,
    output logic                         err_o
);
    localparam int CNT_W = $clog2(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_SHIFT,
        S_PAD
    } state_e;

    logic sclk_s, lrck_s, sdin_s;
    logic sclk_prev_q;
    logic rise, ws_edge;

    state_e                       state_q, state_d;
    logic [DATA_WIDTH-1:0]        shreg_q, shreg_d, shreg_nxt;
    logic [CNT_W-1:0]             bitcnt_q, bitcnt_d, bitcnt_inc;
    logic                         lrck_q, lrck_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                         vld_q, vld_d;
    logic                         err_q, err_d;

`ifdef I2S_RX_STEREO_AVG_EN
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic                  left_vld_q, left_vld_d;
    logic [DATA_WIDTH:0]   sum;
    assign sum = {left_q[DATA_WIDTH-1], left_q} + {shreg_nxt[DATA_WIDTH-1], shreg_nxt};
`endif

    sync_2ff u_sync_sclk (.clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s));
    sync_2ff u_sync_lrck (.clk(clk), .rst(rst), .d_i(lrck), .q_o(lrck_s));
    sync_2ff u_sync_sdin (.clk(clk), .rst(rst), .d_i(sdin), .q_o(sdin_s));

    assign rise       = sclk_s & ~sclk_prev_q;
    assign ws_edge    = rise && (lrck_s != lrck_q);
    assign shreg_nxt  = {shreg_q[DATA_WIDTH-2:0], sdin_s};
    assign bitcnt_inc = bitcnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        lrck_d   = lrck_q;
        data_d   = data_q;
        vld_d    = 1'b0;
        err_d    = 1'b0;
`ifdef I2S_RX_STEREO_AVG_EN
        left_d     = left_q;
        left_vld_d = left_vld_q;
`endif
        if (rise) begin
            lrck_d = lrck_s;
            unique case (state_q)
                S_IDLE: begin
                    if (ws_edge) state_d = S_DELAY;
                end
                // A repeated word-select edge here just restarts the delay bit.
                S_DELAY: begin
                    if (!ws_edge) begin
                        shreg_d  = {{(DATA_WIDTH-1){1'b0}}, sdin_s};
                        bitcnt_d = CNT_W'(1);
                        state_d  = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ws_edge) begin
                        err_d    = 1'b1;
                        bitcnt_d = '0;
                        state_d  = S_DELAY;
`ifdef I2S_RX_STEREO_AVG_EN
                        left_vld_d = 1'b0;
`endif
                    end else begin
                        shreg_d  = shreg_nxt;
                        bitcnt_d = bitcnt_inc;
                        if (bitcnt_inc == CNT_WORD) begin
                            state_d = S_PAD;
`ifdef I2S_RX_STEREO_AVG_EN
                            if (!lrck_q) begin
                                left_d     = shreg_nxt;
                                left_vld_d = 1'b1;
                            end else if (left_vld_q) begin
                                data_d     = sum[DATA_WIDTH:1];
                                vld_d      = 1'b1;
                                left_vld_d = 1'b0;
                            end
`else
                            if (!lrck_q) begin
                                data_d = shreg_nxt;
                                vld_d  = 1'b1;
                            end
`endif
                        end
                    end
                end
                S_PAD: begin
                    if (ws_edge) begin
                        bitcnt_d = '0;
                        state_d  = S_DELAY;
                    end else if (bitcnt_q != CNT_MAX) begin
                        bitcnt_d = bitcnt_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            lrck_q      <= 1'b0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef I2S_RX_STEREO_AVG_EN
            left_q      <= '0;
            left_vld_q  <= 1'b0;
`endif
        end else begin
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            lrck_q      <= lrck_d;
            data_q      <= data_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
`ifdef I2S_RX_STEREO_AVG_EN
            left_q      <= left_d;
            left_vld_q  <= left_vld_d;
`endif
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;
    assign err_o  = err_q;
endmodule

// File: doc/i2s_rx.md
# i2s_rx

Front-end audio stage: deserialises the codec's I2S ADC stream (bit clock, word select, serial data, all asynchronous to `clk`) into signed parallel samples with a one-cycle valid strobe. It sits directly upstream of the effect chain (flanger and siblings). Its `data_o`/`vld_o` connect one-to-one to an effect's `data_i`/`vld_i`.

## Interface
- `DATA_WIDTH`, 24: sample width in bits; signed two's complement, MSB first on the wire.
- `SLOT_BITS`, 32: maximum number of sclk rises counted per channel slot; sets the bit-counter width, `$clog2(SLOT_BITS+1)`.
- `clk  in  1`: system clock. It must be at least 4× the sclk frequency.
- `rst  in  1`: asynchronous, active-low reset.
- `sclk  in  1`: I2S bit clock, asynchronous to `clk`.
- `lrck  in  1`: I2S word select, asynchronous. 0 = left, 1 = right.
- `sdin  in  1`: I2S serial data, asynchronous.
- `data_o  out  DATA_WIDTH`: captured sample, signed. It holds its value between strobes.
- `vld_o  out  1`: one-`clk` pulse when `data_o` is updated.
- `err_o  out  1`: one-`clk` pulse when a slot ends before `DATA_WIDTH` bits have been captured.

## Operation
- Synchronisation:
  - `sclk`, `lrck` and `sdin` each pass through a 2-flop synchroniser.
  - `rise` is a 1-cycle strobe on the synchronised `sclk` 0→1 transition.
  - `lrck` and `sdin` are sampled only on `rise`.
- `lrck_q` holds `lrck` as sampled at the previous `rise`. `ws_edge` = (`rise` && sampled `lrck` != `lrck_q`).
- State machine:
  - IDLE (reset state): wait for `ws_edge`, then go to DELAY. Nothing is captured before the first edge after reset.
  - DELAY: the `rise` that produced `ws_edge` carries the previous slot's trailing bit and is discarded. On the next `rise`, shift in bit 0 (the MSB), set `bitcnt` = 1, and go to SHIFT.
  - SHIFT: each `rise` shifts `sdin` into `shreg` LSB-ward, MSB first, and increments `bitcnt`. When `bitcnt` reaches `DATA_WIDTH`, complete the word and go to PAD.
  - PAD: ignore bits until `ws_edge`, then go to DELAY. `bitcnt` saturates at `SLOT_BITS`.
- Word completion in the left slot (`lrck_q` = 0): `data_o` ← `shreg`, and `vld_o` pulses. Right-slot words are discarded unless `I2S_RX_STEREO_AVG_EN` is defined.
- Short slot: `ws_edge` while in SHIFT.
  - The partial word is dropped, `err_o` pulses, and the FSM goes to DELAY.
  - `data_o` is unchanged.
- If `ws_edge` and word completion occur on the same `rise`, completion is not possible. The 24th bit and the delay slot are distinct rises.
- Reset (async assert, synchronous-release design assumed upstream):
  - State = IDLE.
  - `data_o` = 0, `vld_o` = 0, `err_o` = 0.
  - `shreg`, `bitcnt` and `lrck_q` = 0.
  - Synchroniser flops = 0.
- Reset asserted mid-word aborts the word; no partial output is produced.

## Timing
- `vld_o` goes high exactly 1 `clk` after the internal `rise` strobe of the `DATA_WIDTH`-th bit. That is 3–4 `clk` after the external sclk edge, including the synchroniser.
- `vld_o` and `err_o` are never high for more than one cycle, and never high in the same cycle.
- Output rate: one `vld_o` per lrck period, i.e. fs.
- No backpressure. Downstream must accept every strobe.

## Configuration
- `I2S_RX_STEREO_AVG_EN`:
  - Undefined: mono-left output as described above.
  - Defined:
    - The completed left word is held in `left_q`.
    - On completion of the following right word, `data_o` ← (sign-extend(`left_q`) + sign-extend(right)) >>> 1, truncated to `DATA_WIDTH` bits, and `vld_o` pulses.
    - A short right slot clears the pending left word and pulses `err_o`.
    - A right word with no pending left word is discarded silently.

## Structure
- The shared package `audio_pkg` holds `SAMPLE_W` = 24 and `typedef logic signed [SAMPLE_W-1:0] sample_t`.
- The FSM state enum stays local to `i2s_rx`.
- One sub-module, `sync_2ff`: a 1-bit 2-flop synchroniser with async active-low reset, instantiated three times.

## Test plan
- Left word 24'h123456, right word 24'hABCDEF, sclk = 64·fs, `clk` = 8× sclk → `data_o` = 24'h123456 with a single `vld_o` pulse; the right word produces no strobe.
- Same stimulus with `I2S_RX_STEREO_AVG_EN` defined, L = 24'h000100, R = 24'hFFFF00 (−256) → `data_o` = 24'h000000. With L = R = 24'h7FFFFF → `data_o` = 24'h7FFFFF (no overflow).
- Left slot truncated to 16 sclk rises → `err_o` single pulse, no `vld_o`, `data_o` keeps its previous value. The next full frame recovers normally.
- Reset released mid-frame → no output until the first full left slot after a `ws_edge`. The first `vld_o` carries exactly that word.
- `rst` asserted 3 cycles into SHIFT → outputs go to 0 immediately (asynchronously). After release, the following frame captures correctly.
- Back-to-back 100 random frames → one `vld_o` per frame, values match the model bit-exactly, and the `vld_o` spacing equals the lrck period ±1 `clk`.
